// File: rtl/sa_inst_sequencer.sv
// ----------------------------------------------------------------------------
// sa_inst_sequencer
//
// Instruction queue and issue controller for the systolic array instruction
// port. Host words are buffered in a circular FIFO. Words are issued one at a
// time using the array's init_inst_pulse / idle_flag / flag handshake, and the
// block waits for each one to complete before issuing the next. It also keeps
// issue and completion counters and raises a sticky timeout error.
//
// Ports
//   clk             system clock, all logic on the rising edge
//   reset           synchronous active-high reset
//   enable          1 = allowed to start new instructions
//   clear_err       single-cycle pulse, leaves ERROR and clears timeout_err
//   s_inst_valid    host instruction valid
//   s_inst_ready    FIFO can accept a word
//   s_inst_data     host instruction word
//   init_inst_pulse start request to the array
//   instruction     instruction presented to the array
//   idle_flag       array is idle
//   flag            array finished the current instruction
//   fifo_count      number of queued words
//   busy            state is not IDLE or FIFO is not empty
//   issued_cnt      instructions issued (wraps)
//   done_cnt        instructions completed (wraps)
//   timeout_err     sticky timeout indication
// ----------------------------------------------------------------------------
module sa_inst_sequencer #(
  parameter int INST_BITS      = 64,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_BITS       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear_err,
  input  logic                     s_inst_valid,
  output logic                     s_inst_ready,
  input  logic [INST_BITS-1:0]     s_inst_data,
  output logic                     init_inst_pulse,
  output logic [INST_BITS-1:0]     instruction,
  input  logic                     idle_flag,
  input  logic                     flag,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic [CNT_BITS-1:0]      issued_cnt,
  output logic [CNT_BITS-1:0]      done_cnt,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Timeout counter only needs to reach TIMEOUT_CYCLES; keep 1 bit when disabled.
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RECOVER = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  logic [INST_BITS-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  state_e               state_q, state_d;
  logic                 pulse_q, pulse_d;
  logic [INST_BITS-1:0] inst_q, inst_d;
  logic [CNT_BITS-1:0]  issued_q, issued_d;
  logic [CNT_BITS-1:0]  done_q, done_d;
  logic                 terr_q, terr_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [TO_W-1:0]      to_next_s;

  logic                 push_s;
  logic                 pop_s;

  // Ready comes from the registered count, so a full FIFO never accepts a
  // word even when a pop happens in the same cycle.
  assign push_s    = s_inst_valid & ready_q;
  assign to_next_s = to_q + TO_W'(1);

  // Issue state machine: next state, pop request and registered output values.
  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    inst_d   = inst_q;
    issued_d = issued_q;
    done_d   = done_q;
    terr_d   = terr_q;
    to_d     = to_q;
    pop_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (count_q != '0) && idle_flag) begin
          pop_s    = 1'b1;
          inst_d   = mem_q[rd_ptr_q];
          pulse_d  = 1'b1;
          issued_d = issued_q + CNT_BITS'(1);
          to_d     = '0;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        to_d = to_next_s;
        // The array acknowledges the start by dropping idle_flag.
        if (!idle_flag) begin
          pulse_d = 1'b0;
          state_d = S_WAIT;
        end else if (TO_EN && (to_next_s == TO_LIMIT)) begin
          pulse_d = 1'b0;
          terr_d  = 1'b1;
          state_d = S_ERROR;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        to_d = to_next_s;
        // A completion seen on the expiry cycle still counts as done.
        if (flag) begin
          done_d  = done_q + CNT_BITS'(1);
          state_d = S_RECOVER;
        end else if (TO_EN && (to_next_s == TO_LIMIT)) begin
          pulse_d = 1'b0;
          terr_d  = 1'b1;
          state_d = S_ERROR;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RECOVER: begin
        if (idle_flag) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RECOVER;
        end
      end
      S_ERROR: begin
        pulse_d = 1'b0;
        if (clear_err) begin
          terr_d  = 1'b0;
          state_d = S_RECOVER;
        end else begin
          state_d = S_ERROR;
        end
      end
      default: begin
        pulse_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer/count update plus next values of the status outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < DEPTH_C);
    busy_d  = (state_d != S_IDLE) || (count_d != '0);
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_q[wr_ptr_q] <= s_inst_data;
    end
  end

  // State, FIFO bookkeeping and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      state_q  <= S_IDLE;
      pulse_q  <= 1'b0;
      inst_q   <= '0;
      issued_q <= '0;
      done_q   <= '0;
      terr_q   <= 1'b0;
      to_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      inst_q   <= inst_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      to_q     <= to_d;
    end
  end

  assign s_inst_ready    = ready_q;
  assign fifo_count      = count_q;
  assign busy            = busy_q;
  assign init_inst_pulse = pulse_q;
  assign instruction     = inst_q;
  assign issued_cnt      = issued_q;
  assign done_cnt        = done_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_sa_inst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sa_inst_sequencer
//
// Directed bench for sa_inst_sequencer with DEPTH=16, TIMEOUT_CYCLES=20 and
// CNT_BITS=4. The bench plays the array side of the handshake itself:
// inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_sa_inst_sequencer;

  localparam int IB    = 64;
  localparam int DEPTH = 16;
  localparam int TO    = 20;
  localparam int CB    = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic                     clear_err;
  logic                     s_inst_valid;
  logic                     s_inst_ready;
  logic [IB-1:0]            s_inst_data;
  logic                     init_inst_pulse;
  logic [IB-1:0]            instruction;
  logic                     idle_flag;
  logic                     flag;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     busy;
  logic [CB-1:0]            issued_cnt;
  logic [CB-1:0]            done_cnt;
  logic                     timeout_err;

  int checks   = 0;
  int failures = 0;
  int exp_issued = 0;
  int exp_done   = 0;

  always #5 clk = ~clk;

  sa_inst_sequencer #(
    .INST_BITS      (IB),
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TO),
    .CNT_BITS       (CB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .clear_err       (clear_err),
    .s_inst_valid    (s_inst_valid),
    .s_inst_ready    (s_inst_ready),
    .s_inst_data     (s_inst_data),
    .init_inst_pulse (init_inst_pulse),
    .instruction     (instruction),
    .idle_flag       (idle_flag),
    .flag            (flag),
    .fifo_count      (fifo_count),
    .busy            (busy),
    .issued_cnt      (issued_cnt),
    .done_cnt        (done_cnt),
    .timeout_err     (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [63:0] w);
    s_inst_valid = 1'b1;
    s_inst_data  = w;
    @(negedge clk);
    s_inst_valid = 1'b0;
  endtask

  // Waits (bounded) for the start pulse, then checks word and issue count.
  task automatic wait_pulse(input logic [63:0] w, input string tag);
    logic [CB-1:0] ei;
    int n;
    n = 0;
    while (init_inst_pulse !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, " pulse"}, 64'(init_inst_pulse), 64'd1);
    check({tag, " instr"}, instruction, w);
    exp_issued++;
    ei = CB'(exp_issued);
    check({tag, " issued"}, 64'(issued_cnt), 64'(ei));
  endtask

  // Array model for one instruction: stay idle for 'hold' cycles after the
  // pulse, drop idle_flag, then raise flag 'fdelay' cycles later.
  task automatic serve(input logic [63:0] w, input int hold, input int fdelay, input string tag);
    logic [CB-1:0] ed;
    wait_pulse(w, tag);
    repeat (hold) begin
      @(negedge clk);
      check({tag, " hold pulse"}, 64'(init_inst_pulse), 64'd1);
      check({tag, " hold instr"}, instruction, w);
    end
    idle_flag = 1'b0;
    @(negedge clk);
    check({tag, " pulse drop"}, 64'(init_inst_pulse), 64'd0);
    repeat (fdelay - 1) @(negedge clk);
    flag      = 1'b1;
    idle_flag = 1'b1;
    @(negedge clk);
    flag = 1'b0;
    exp_done++;
    ed = CB'(exp_done);
    check({tag, " done"}, 64'(done_cnt), 64'(ed));
  endtask

  initial begin
    logic [CB-1:0] snap_done;
    reset        = 1'b1;
    enable       = 1'b1;
    clear_err    = 1'b0;
    s_inst_valid = 1'b0;
    s_inst_data  = '0;
    idle_flag    = 1'b1;
    flag         = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst fifo_count", 64'(fifo_count), 64'd0);
    check("rst ready", 64'(s_inst_ready), 64'd1);
    check("rst pulse", 64'(init_inst_pulse), 64'd0);
    check("rst instr", instruction, 64'd0);
    check("rst issued", 64'(issued_cnt), 64'd0);
    check("rst done", 64'(done_cnt), 64'd0);
    check("rst terr", 64'(timeout_err), 64'd0);
    check("rst busy", 64'(busy), 64'd0);

    // 1: three words issued in order
    push(64'h11);
    push(64'h22);
    push(64'h33);
    serve(64'h11, 2, 10, "t1 w0");
    serve(64'h22, 2, 10, "t1 w1");
    serve(64'h33, 2, 10, "t1 w2");
    tick();
    check("t1 issued", 64'(issued_cnt), 64'd3);
    check("t1 done", 64'(done_cnt), 64'd3);
    check("t1 busy", 64'(busy), 64'd0);

    // 2: fill FIFO with enable low, 17th push refused, then drain in order
    enable = 1'b0;
    for (int i = 0; i < 17; i++) push(64'hA0 + 64'(i));
    check("t2 count full", 64'(fifo_count), 64'd16);
    check("t2 ready full", 64'(s_inst_ready), 64'd0);
    check("t2 busy", 64'(busy), 64'd1);
    check("t2 no pulse", 64'(init_inst_pulse), 64'd0);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) serve(64'hA0 + 64'(i), 2, 4, "t2 drain");
    tick();
    check("t2 count empty", 64'(fifo_count), 64'd0);
    check("t2 issued wrap", 64'(issued_cnt), 64'd3);

    // 3: idle_flag held 5 cycles after the pulse
    push(64'h5A5A_0000_0000_A5A5);
    serve(64'h5A5A_0000_0000_A5A5, 5, 10, "t3");

    // 4: timeout after 20 cycles, then clear_err resumes the queue
    enable = 1'b0;
    push(64'h101);
    push(64'h102);
    push(64'h103);
    enable = 1'b1;
    snap_done = done_cnt;
    wait_pulse(64'h101, "t4 w0");
    repeat (2) tick();
    idle_flag = 1'b0;
    repeat (17) tick();
    check("t4 terr before", 64'(timeout_err), 64'd0);
    tick();
    check("t4 terr set", 64'(timeout_err), 64'd1);
    check("t4 pulse low", 64'(init_inst_pulse), 64'd0);
    check("t4 done held", 64'(done_cnt), 64'(snap_done));
    check("t4 fifo kept", 64'(fifo_count), 64'd2);
    idle_flag = 1'b1;
    repeat (2) tick();
    check("t4 stays error", 64'(init_inst_pulse), 64'd0);
    check("t4 terr sticky", 64'(timeout_err), 64'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4 terr cleared", 64'(timeout_err), 64'd0);
    serve(64'h102, 2, 10, "t4 w1");
    serve(64'h103, 2, 10, "t4 w2");

    // 5: reset while waiting for flag with 4 words queued
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push(64'h201 + 64'(i));
    enable = 1'b1;
    wait_pulse(64'h201, "t5");
    idle_flag = 1'b0;
    tick();
    check("t5 in wait pulse", 64'(init_inst_pulse), 64'd0);
    check("t5 queued", 64'(fifo_count), 64'd4);
    reset     = 1'b1;
    idle_flag = 1'b1;
    tick();
    reset = 1'b0;
    check("t5 count", 64'(fifo_count), 64'd0);
    check("t5 pulse", 64'(init_inst_pulse), 64'd0);
    check("t5 instr", instruction, 64'd0);
    check("t5 issued", 64'(issued_cnt), 64'd0);
    check("t5 done", 64'(done_cnt), 64'd0);
    check("t5 terr", 64'(timeout_err), 64'd0);
    check("t5 ready", 64'(s_inst_ready), 64'd1);
    check("t5 busy", 64'(busy), 64'd0);
    exp_issued = 0;
    exp_done   = 0;
    repeat (2) tick();
    check("t5 stays idle", 64'(init_inst_pulse), 64'd0);

    // 6: 17 instructions wrap the 4-bit counters to 1
    for (int i = 0; i < 17; i++) begin
      push(64'h300 + 64'(i));
      serve(64'h300 + 64'(i), 1, 2, "t6");
    end
    tick();
    check("t6 issued wrap", 64'(issued_cnt), 64'd1);
    check("t6 done wrap", 64'(done_cnt), 64'd1);
    check("t6 busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
